arb_mux2: RTL and testbench

ARB_MUX2 -- requirements
Module: arb_mux2

---
 rtl/mux_pkg.sv | 24 ++
 rtl/mux2.sv | 17 +
 rtl/rr_arb2.sv | 14 +
 rtl/arb_mux2.sv | 78 +++++++
 tb/tb_arb_mux2.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the two-input arbitrated mux: source encodings and
// the default payload width.
package mux_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Round-robin pick for two requesters: a lone request wins, contention
    // goes to the source that did not win last, idle keeps the last grant.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        logic pick;
        pick = last_grant;
        case (req)
            2'b01:   pick = SRC_A;
            2'b10:   pick = SRC_B;
            2'b11:   pick = ~last_grant;
            default: pick = last_grant;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/mux2.sv
// Bitwise 2:1 multiplexer cell; sel=0 passes d0, sel=1 passes d1.
module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] y
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y[gi] = sel ? d1[gi] : d0[gi];
        end
    endgenerate

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0] is channel A, req[1] is channel B.
module rr_arb2
    import mux_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = rr_pick(req, last_grant);
    end

endmodule

// File: rtl/arb_mux2.sv
// Two-channel round-robin arbiter feeding a single registered output slot;
// sustains one word per cycle when the consumer drains while a new word loads.
module arb_mux2
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel
);

    logic             last_grant_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_src_reg;

    logic             load_en;
    logic             grant;
    logic             take;
    logic [WIDTH-1:0] mux_data;

    // The output slot can accept a word when empty or being drained this cycle.
    assign load_en = !out_valid_reg || out_ready;

    rr_arb2 u_arb (
        .req        ({b_valid, a_valid}),
        .last_grant (last_grant_reg),
        .grant      (grant)
    );

    assign sel = grant;

    // Readies are masked during reset so nothing is handshaken while the slot clears.
    assign a_ready = !rst && load_en && (grant == SRC_A) && a_valid;
    assign b_ready = !rst && load_en && (grant == SRC_B) && b_valid;
    assign take    = a_ready || b_ready;

    mux2 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel (sel),
        .d0  (a_data),
        .d1  (b_data),
        .y   (mux_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_src_reg    <= SRC_A;
            last_grant_reg <= SRC_B;
        end else if (take) begin
            out_valid_reg  <= 1'b1;
            out_data_reg   <= mux_data;
            out_src_reg    <= grant;
            last_grant_reg <= grant;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;

endmodule

// File: tb/tb_arb_mux2.sv
// Self-checking bench for arb_mux2: directed vector table, hand-written
// corner sequences, and a randomized run checked through a scoreboard queue.
module tb_arb_mux2;

    logic       clk;
    logic       rst;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src;
    logic       out_ready;
    logic       sel;

    int checks = 0;
    int errors = 0;

    logic [8:0] q[$];

    arb_mux2 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       ordy;
        logic       ar;
        logic       br;
        logic       sl;
        logic       ov;
        logic [7:0] od;
        logic       os;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [8:0] e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_underflow actual=word src=%0d data=%02h required=no word", tag, out_src, out_data);
        end else begin
            e = q.pop_front();
            chk({tag, "_out_valid"}, 32'(out_valid), 32'(1));
            chk({tag, "_out_src"}, 32'(out_src), 32'(e[8]));
            chk({tag, "_out_data"}, 32'(out_data), 32'(e[7:0]));
            $display("%s word src=%0d data=%02h", tag, e[8], e[7:0]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b1; a_data = 8'hAA;
        b_valid = 1'b1; b_data = 8'hBB;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_src", 32'(out_src), 32'(0));
        chk("rst_a_ready", 32'(a_ready), 32'(0));
        chk("rst_b_ready", 32'(b_ready), 32'(0));
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("rst_last_grant_b", 32'(sel), 32'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        $display("reset done");
    endtask

    initial begin
        logic mov, mlg, g, le, ear, ebr;
        logic [6:0] a_cnt, b_cnt;
        int accepted, produced;

        rst = 1'b1;
        a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        out_ready = 1'b0;

        //            av  ad     bv  bd     rdy  ar br sl ov  od     os
        tbl[0]  = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0};
        tbl[2]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0};
        tbl[3]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1};
        tbl[4]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[5]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[6]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b1};
        tbl[10] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0};
        tbl[13] = '{1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0};

        @(posedge clk); #1;
        do_reset();

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            a_valid = tbl[i].av; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_data = tbl[i].bd;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].ar));
            chk($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].br));
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(tbl[i].sl));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
            chk($sformatf("vec%0d_out_src", i), 32'(out_src), 32'(tbl[i].os));
            $display("vec %0d av=%0d bv=%0d rdy=%0d -> ar=%0d br=%0d sel=%0d ov=%0d od=%02h os=%0d",
                     i, a_valid, b_valid, out_ready, a_ready, b_ready, sel, out_valid, out_data, out_src);
            @(posedge clk); #1;
        end

        // Alternating contention with back-to-back drain.
        do_reset();
        a_valid = 1'b1; a_data = 8'h11;
        b_valid = 1'b1; b_data = 8'h22;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) pop_check("rr");
            chk($sformatf("rr%0d_sel", i), 32'(sel), 32'(i % 2));
            q.push_back((i % 2 == 1) ? 9'h122 : 9'h011);
            @(posedge clk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        pop_check("rr");
        @(posedge clk); #1;

        // Reset while a word is held discards it and restarts contention at A.
        a_valid = 1'b1; a_data = 8'hA5; out_ready = 1'b0;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        chk("hold_out_valid", 32'(out_valid), 32'(1));
        chk("hold_out_data", 32'(out_data), 32'(8'hA5));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_out_data", 32'(out_data), 32'(0));
        a_valid = 1'b1; a_data = 8'h5A;
        b_valid = 1'b1; b_data = 8'hC3;
        #1;
        chk("midrst_sel", 32'(sel), 32'(0));
        chk("midrst_a_ready", 32'(a_ready), 32'(1));
        chk("midrst_b_ready", 32'(b_ready), 32'(0));
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_word_data", 32'(out_data), 32'(8'h5A));
        chk("midrst_word_src", 32'(out_src), 32'(0));
        $display("midrst word src=%0d data=%02h", out_src, out_data);
        @(posedge clk); #1;

        // Lone B request right after reset.
        do_reset();
        b_valid = 1'b1; b_data = 8'hF0; out_ready = 1'b0;
        @(negedge clk);
        chk("bonly_sel", 32'(sel), 32'(1));
        chk("bonly_b_ready", 32'(b_ready), 32'(1));
        chk("bonly_a_ready", 32'(a_ready), 32'(0));
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(negedge clk);
        chk("bonly_out_data", 32'(out_data), 32'(8'hF0));
        chk("bonly_out_src", 32'(out_src), 32'(1));
        $display("bonly word src=%0d data=%02h", out_src, out_data);
        @(posedge clk); #1;

        // Random traffic against a scoreboard.
        do_reset();
        mov = 1'b0; mlg = 1'b1;
        a_cnt = '0; b_cnt = '0;
        accepted = 0; produced = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            a_data = {1'b0, a_cnt};
            b_data = {1'b1, b_cnt};
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            case ({b_valid, a_valid})
                2'b01:   g = 1'b0;
                2'b10:   g = 1'b1;
                2'b11:   g = ~mlg;
                default: g = mlg;
            endcase
            le  = !mov || out_ready;
            ear = le && !g && a_valid;
            ebr = le && g && b_valid;
            chk("rnd_a_ready", 32'(a_ready), 32'(ear));
            chk("rnd_b_ready", 32'(b_ready), 32'(ebr));
            chk("rnd_sel", 32'(sel), 32'(g));
            chk("rnd_out_valid", 32'(out_valid), 32'(mov));
            if (out_valid && out_ready) begin
                produced++;
                pop_check("rnd");
            end
            if (ear) begin
                q.push_back({1'b0, a_data});
                a_cnt++;
                accepted++;
            end
            if (ebr) begin
                q.push_back({1'b1, b_data});
                b_cnt++;
                accepted++;
            end
            if (ear || ebr) begin
                mov = 1'b1;
                mlg = g;
            end else if (out_ready) begin
                mov = 1'b0;
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) begin
                produced++;
                pop_check("drain");
            end
            @(posedge clk); #1;
        end
        chk("rnd_queue_empty", 32'(q.size()), 32'(0));
        chk("rnd_count", 32'(produced), 32'(accepted));
        $display("random accepted=%0d produced=%0d", accepted, produced);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
